// File: rtl/echo_capture.sv
// HC-SR04 echo receiver: arms on start, waits for the echo rising edge and
// measures the echo high time in clk cycles, reporting no-echo and saturation.
module echo_capture #(
   parameter int unsigned CNT_LEN     = 16,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               echo,
   input  logic [CNT_LEN-1:0] timeout,
   output logic               ready,
   output logic               valid,
   output logic [CNT_LEN-1:0] width,
   output logic [1:0]         err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      MEASURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK     = 2'b00;
   localparam logic [1:0] ERR_NOECHO = 2'b01;
   localparam logic [1:0] ERR_SAT    = 2'b10;

   state_t                 state, state_d;
   logic [SYNC_STAGES-1:0] sync;
   logic                   echo_s, echo_prev, rise, fall;
   logic [CNT_LEN-1:0]     wait_cnt, wait_cnt_d;
   logic [CNT_LEN-1:0]     tmo_q, tmo_d;
   logic [CNT_LEN-1:0]     width_cnt, width_cnt_d;
   logic [CNT_LEN-1:0]     width_d;
   logic [1:0]             err_d;

   assign echo_s = sync[SYNC_STAGES-1];
   assign rise   = echo_s & ~echo_prev;
   assign fall   = ~echo_s & echo_prev;

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         sync      <= '0;
         echo_prev <= 1'b0;
         wait_cnt  <= '0;
         tmo_q     <= '0;
         width_cnt <= '0;
         width     <= '0;
         err       <= ERR_OK;
         valid     <= 1'b0;
         ready     <= 1'b1;
      end else begin
         state     <= state_d;
         sync      <= {sync[SYNC_STAGES-2:0], echo};
         echo_prev <= echo_s;
         wait_cnt  <= wait_cnt_d;
         tmo_q     <= tmo_d;
         width_cnt <= width_cnt_d;
         width     <= width_d;
         err       <= err_d;
         valid     <= (state_d == DONE);
         ready     <= (state_d == IDLE);
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d     = state;
      wait_cnt_d  = wait_cnt;
      tmo_d       = tmo_q;
      width_cnt_d = width_cnt;
      width_d     = width;
      err_d       = err;
      case (state)
         IDLE: begin
            if (start) begin
               state_d    = ARMED;
               wait_cnt_d = '0;
               tmo_d      = timeout;
            end
         end
         ARMED: begin
            wait_cnt_d = wait_cnt + CNT_LEN'(1);
            if (rise) begin
               state_d     = MEASURE;
               width_cnt_d = CNT_LEN'(1);
            end else if (wait_cnt == tmo_q) begin
               state_d = DONE;
               width_d = '0;
               err_d   = ERR_NOECHO;
            end
         end
         MEASURE: begin
            // saturation is tested before the increment so the counter never wraps
            if (fall) begin
               state_d = DONE;
               width_d = width_cnt;
               err_d   = ERR_OK;
            end else if (&width_cnt) begin
               state_d = DONE;
               width_d = '1;
               err_d   = ERR_SAT;
            end else begin
               width_cnt_d = width_cnt + CNT_LEN'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_echo_capture.sv
// Directed self-checking bench for echo_capture (CNT_LEN=8, two sync stages).
module tb_echo_capture;

   localparam int unsigned CNT_LEN = 8;

   logic               clk;
   logic               rst;
   logic               start;
   logic               echo;
   logic [CNT_LEN-1:0] timeout;
   logic               ready;
   logic               valid;
   logic [CNT_LEN-1:0] width;
   logic [1:0]         err;

   int checks;
   int errors;
   int cyc;
   int vcount;
   logic [CNT_LEN-1:0] vw [0:3];
   logic [1:0]         ve [0:3];
   int                 vc [0:3];
   logic prev_v;
   logic rdy_after;

   echo_capture #(.CNT_LEN(CNT_LEN), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .echo(echo), .timeout(timeout),
      .ready(ready), .valid(valid), .width(width), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock, sample just after the edge and log any valid strobe
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (prev_v) rdy_after = ready;
      prev_v = valid;
      if (valid) begin
         if (vcount < 4) begin
            vw[vcount] = width;
            ve[vcount] = err;
            vc[vcount] = cyc;
         end
         vcount++;
      end
   endtask

   task automatic clear_log();
      vcount    = 0;
      rdy_after = 1'b0;
      prev_v    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; echo = 1'b1; start = 1'b0; timeout = '0;
      clear_log();
      repeat (3) step();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (width !== 8'd0) begin errors++; $display("FAIL reset_width got %0d want 0", width); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", err); end
      rst = 1'b1;
      repeat (8) step();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", ready); end
      checks++; if (vcount !== 0) begin errors++; $display("FAIL idle_no_valid got %0d want 0", vcount); end
      echo = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_nominal();
      clear_log();
      timeout = 8'd100;
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL armed_ready got %b want 0", ready); end
      repeat (9) step();
      echo = 1'b1;
      repeat (37) step();
      echo = 1'b0;
      repeat (20) step();
      checks++; if (vcount !== 1) begin errors++; $display("FAIL nom_count got %0d want 1", vcount); end
      checks++; if (vw[0] !== 8'd37) begin errors++; $display("FAIL nom_width got %0d want 37", vw[0]); end
      checks++; if (ve[0] !== 2'b00) begin errors++; $display("FAIL nom_err got %b want 00", ve[0]); end
      checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL nom_ready_after got %b want 1", rdy_after); end
   endtask

   task automatic test_no_echo(input logic [CNT_LEN-1:0] tmo, input int exp_lat);
      int c0;
      clear_log();
      timeout = tmo;
      start = 1'b1;
      step();
      start = 1'b0;
      c0 = cyc;
      repeat (40) step();
      checks++; if (vcount !== 1) begin errors++; $display("FAIL noecho_count tmo=%0d got %0d want 1", tmo, vcount); end
      checks++; if (vc[0] - c0 !== exp_lat) begin errors++; $display("FAIL noecho_latency tmo=%0d got %0d want %0d", tmo, vc[0] - c0, exp_lat); end
      checks++; if (vw[0] !== 8'd0) begin errors++; $display("FAIL noecho_width got %0d want 0", vw[0]); end
      checks++; if (ve[0] !== 2'b01) begin errors++; $display("FAIL noecho_err got %b want 01", ve[0]); end
   endtask

   task automatic test_saturation();
      clear_log();
      timeout = 8'd200;
      start = 1'b1;
      echo = 1'b1;
      step();
      start = 1'b0;
      repeat (399) step();
      echo = 1'b0;
      repeat (20) step();
      checks++; if (vcount !== 1) begin errors++; $display("FAIL sat_count got %0d want 1", vcount); end
      checks++; if (vw[0] !== 8'd255) begin errors++; $display("FAIL sat_width got %0d want 255", vw[0]); end
      checks++; if (ve[0] !== 2'b10) begin errors++; $display("FAIL sat_err got %b want 10", ve[0]); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL sat_ready got %b want 1", ready); end
   endtask

   task automatic test_pre_high();
      clear_log();
      echo = 1'b1;
      repeat (6) step();
      timeout = 8'd200;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      echo = 1'b0;
      repeat (5) step();
      echo = 1'b1;
      repeat (12) step();
      echo = 1'b0;
      repeat (20) step();
      checks++; if (vcount !== 1) begin errors++; $display("FAIL prehigh_count got %0d want 1", vcount); end
      checks++; if (vw[0] !== 8'd12) begin errors++; $display("FAIL prehigh_width got %0d want 12", vw[0]); end
      checks++; if (ve[0] !== 2'b00) begin errors++; $display("FAIL prehigh_err got %b want 00", ve[0]); end
   endtask

   task automatic test_abort();
      clear_log();
      timeout = 8'd200;
      start = 1'b1;
      step();
      start = 1'b0;
      echo = 1'b1;
      repeat (10) step();
      rst = 1'b0;
      #1;
      checks++; if (width !== 8'd0) begin errors++; $display("FAIL abort_width got %0d want 0", width); end
      checks++; if (err !== 2'b00) begin errors++; $display("FAIL abort_err got %b want 00", err); end
      repeat (2) step();
      echo = 1'b0;
      rst = 1'b1;
      repeat (10) step();
      checks++; if (vcount !== 0) begin errors++; $display("FAIL abort_no_valid got %0d want 0", vcount); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", ready); end
   endtask

   task automatic test_back_to_back();
      clear_log();
      timeout = 8'd200;
      start = 1'b1;
      repeat (2) begin
         repeat (5) step();
         echo = 1'b1;
         repeat (8) step();
         echo = 1'b0;
         repeat (15) step();
      end
      start = 1'b0;
      repeat (10) step();
      checks++; if (vcount !== 2) begin errors++; $display("FAIL b2b_count got %0d want 2", vcount); end
      checks++; if (vw[0] !== 8'd8 || ve[0] !== 2'b00) begin errors++; $display("FAIL b2b_first got w=%0d e=%b want w=8 e=00", vw[0], ve[0]); end
      checks++; if (vw[1] !== 8'd8 || ve[1] !== 2'b00) begin errors++; $display("FAIL b2b_second got w=%0d e=%b want w=8 e=00", vw[1], ve[1]); end
      checks++; if (vc[1] - vc[0] < 2) begin errors++; $display("FAIL b2b_gap got %0d want >=2", vc[1] - vc[0]); end
      checks++; if (rdy_after !== 1'b1) begin errors++; $display("FAIL b2b_ready_after got %b want 1", rdy_after); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b0;
      start  = 1'b0;
      echo   = 1'b0;
      timeout = '0;
      clear_log();
      test_reset();
      test_nominal();
      test_no_echo(8'd20, 21);
      test_no_echo(8'd0, 1);
      test_saturation();
      test_pre_high();
      test_abort();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/echo_capture.md
Name: echo_capture

Overview:
- Receive side of the HC-SR04 ranging interface: after the trigger pulse is issued, this block waits for the sensor's echo pulse and measures its high time in clk cycles.
- Sits beside the trigger generator. Its start is driven from the same enable that fires the trigger.
- Presents one result per measurement with a one-cycle valid strobe and an error code for "no echo" and "pulse too long".

Parameters:
- CNT_LEN, 16, width of the echo-width counter, the no-echo wait counter and the timeout input.
- SYNC_STAGES, 2, flip-flop stages on the asynchronous echo input; legal values are 2 or more.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-low reset; the low level clears all state immediately.
- start  input  1  level; sampled only in IDLE; high arms one measurement.
- echo  input  1  raw sensor echo pin, asynchronous to clk.
- timeout  input  CNT_LEN  maximum clk cycles to wait in ARMED for an echo rising edge; sampled on entry to ARMED.
- ready  output  1  high only in IDLE.
- valid  output  1  one-cycle strobe: width and err are updated.
- width  output  CNT_LEN  measured echo high time in clk cycles; holds until the next valid.
- err  output  2  00 ok, 01 no echo within timeout, 10 width counter saturated; holds until the next valid.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, synchronizer flops=0, echo_prev=0.
  - Counters, width and err all 0; valid=0; ready=1 once reset is released.
- Echo path:
  - echo passes through SYNC_STAGES flops to give echo_s.
  - echo_prev is echo_s delayed by one cycle.
  - rise = echo_s & !echo_prev; fall = !echo_s & echo_prev.
- IDLE: when start=1, go to ARMED, wait_cnt=0, latch timeout into tmo_q.
- ARMED:
  - Each cycle wait_cnt increments by 1.
  - If rise: go to MEASURE, width_cnt=1 (the rising-edge cycle counts).
  - Else if wait_cnt==tmo_q: go to DONE, width=0, err=01.
  - rise wins if both occur in the same cycle.
  - tmo_q=0 times out on the first ARMED cycle unless rise is present.
  - Echo already high on entry is not a rise: the block waits for low then high.
- MEASURE:
  - If fall: go to DONE, width=width_cnt, err=00.
  - Else if width_cnt is all ones: go to DONE, width all ones, err=10. The counter never wraps.
  - Else width_cnt increments by 1.
  - Result: an echo_s pulse N cycles wide gives width=N, for 1 <= N < 2^CNT_LEN-1.
- DONE:
  - valid=1 for exactly this cycle, then return to IDLE.
  - width and err registers are updated on the transition into DONE, so they are stable whenever valid=1.
- Busy rules:
  - start is ignored in ARMED, MEASURE and DONE.
  - After valid, ready rises the next cycle. A start held high re-arms on the first IDLE cycle, so the minimum gap between measurements is 1 IDLE cycle.
- Reset mid-operation: an in-flight measurement is abandoned, no valid is produced, and width and err clear to 0.
- Latency: the echo edge reaches the state machine after SYNC_STAGES+1 clk cycles. Rise and fall see the same delay, so width is unaffected.
- Width rules:
  - Counter widths are CNT_LEN.
  - The wait_cnt==tmo_q compare is unsigned, equal width.
  - No arithmetic overflow is possible: the saturation check comes before the increment.

Test Plan:
- Reset: hold rst low for 3 cycles with echo=1 -> ready=1, valid=0, width=0, err=00. Release rst, leave start=0 -> stays IDLE, no rise acted upon.
- Nominal: timeout=100; pulse start for 1 cycle; 10 cycles later drive echo high for 37 clk cycles -> exactly one valid, width=37, err=00, ready=1 on the next cycle.
- No echo: timeout=20, start, echo held 0 -> valid exactly 21 cycles after leaving IDLE (cycles 0..20 in ARMED), width=0, err=01.
- Saturation: CNT_LEN=8, start, echo high for 400 cycles -> valid with width=255, err=10. The later echo fall is ignored; the block returns to IDLE.
- Pre-high echo: echo=1 before start, timeout=200; echo goes low 5 cycles after arming, then high 12 cycles, then low -> width=12, err=00.
- Abort and back-to-back: reset asserted mid-MEASURE -> no valid, width=0, err=00. Then start held high, two 8-cycle echo pulses -> two valids, each width=8, err=00, separated by at least one ready cycle.
